// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding decode from a synchronous-read
// instruction memory. Owns the PC, tracks the one-cycle read latency and
// hands words to decode through a valid/ready handshake; redirects from
// later stages flush the in-flight fetch.
//
// Optional feature macro: IF_BOUNDS_CHECK_EN
//   defined   - misaligned or out-of-range fetch PCs raise a sticky fault
//               that stalls fetch until a redirect to a good PC.
//   undefined - no checking; addressing wraps modulo 2^ADDR_WIDTH words and
//               fault is tied low.
module instruction_fetch #(
   parameter int          ADDR_WIDTH = 10,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [31:0]           if_pc,
   output logic [31:0]           if_pc_plus4,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  halt,
   output logic                  fault
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        inflight_valid_q, inflight_valid_d;
   logic [31:0] fetch_pc;
   logic        advance;
   logic        issue;
   logic        bad_pc;
   logic        fault_q;

   // Fetch PC select: redirect first, then sequential, else re-present the
   // stalled word so the memory output stays stable.
   always_comb begin
      advance  = !inflight_valid_q | id_ready;
      fetch_pc = inflight_pc_q;
      if (redirect_valid)
         fetch_pc = redirect_pc;
      else if (advance)
         fetch_pc = pc_q;
   end

`ifdef IF_BOUNDS_CHECK_EN
   logic fault_d;

   // Bad PC detection and sticky fault tracking.
   always_comb begin
      bad_pc  = (fetch_pc[1:0] != 2'b00) | (fetch_pc[31:ADDR_WIDTH+2] != '0);
      fault_d = fault_q;
      if (redirect_valid && !bad_pc)
         fault_d = 1'b0;
      else if ((redirect_valid | advance) && bad_pc)
         fault_d = 1'b1;
   end

   // Fault register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fault_q <= 1'b0;
      else
         fault_q <= fault_d;
   end
`else
   assign bad_pc  = 1'b0;
   assign fault_q = 1'b0;
`endif

   // Issue decision and next-state for PC and in-flight tracking. A pending
   // fault blocks sequential issue; only a redirect can restart fetch.
   always_comb begin
      issue            = (redirect_valid | (advance & !fault_q)) & !halt & !bad_pc;
      pc_d             = pc_q;
      inflight_pc_d    = inflight_pc_q;
      inflight_valid_d = inflight_valid_q;
      if (redirect_valid | advance) begin
         inflight_valid_d = issue;
         inflight_pc_d    = fetch_pc;
      end
      if (issue)
         pc_d = fetch_pc + 32'd4;
      else if (redirect_valid)
         pc_d = redirect_pc;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q             <= RESET_PC;
         inflight_pc_q    <= 32'h0;
         inflight_valid_q <= 1'b0;
      end else begin
         pc_q             <= pc_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_valid_q <= inflight_valid_d;
      end
   end

   assign mem_addr    = fetch_pc[ADDR_WIDTH+1:2];
   assign if_valid    = inflight_valid_q & !redirect_valid;
   assign if_instr    = mem_data;
   assign if_pc       = inflight_pc_q;
   assign if_pc_plus4 = inflight_pc_q + 32'd4;
   assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_instruction_fetch;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic          id_ready;
   logic          if_valid;
   logic [31:0]   if_instr;
   logic [31:0]   if_pc;
   logic [31:0]   if_pc_plus4;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          halt;
   logic          fault;

   logic [31:0]   mem [1024];

   int n_run  = 0;
   int n_fail = 0;

   instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory model.
   always @(posedge clk) mem_data <= mem[mem_addr];

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      logic [AW-1:0] idx;
      idx = pc[AW+1:2];
      return mem[idx];
   endfunction

   task automatic step;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      id_ready = 1'b1;
      halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      do_reset();
      n_run++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", if_valid); end
      n_run++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", if_pc); end
      n_run++; if (if_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got %h want 4", if_pc_plus4); end
      n_run++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
      n_run++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b want 0", fault); end
   endtask

   task automatic test_free_run;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         step();
         n_run++; if (mem_addr !== AW'(k)) begin n_fail++; $display("FAIL free_addr k=%0d got %h want %h", k, mem_addr, k); end
         n_run++; if (if_valid !== 1'b1 || if_pc !== 32'(4*(k-1)) || if_pc_plus4 !== 32'(4*k))
            begin n_fail++; $display("FAIL free_pc k=%0d got v=%0b pc=%h want pc=%h", k, if_valid, if_pc, 4*(k-1)); end
         n_run++; if (if_instr !== mem[k-1]) begin n_fail++; $display("FAIL free_instr k=%0d got %h want %h", k, if_instr, mem[k-1]); end
      end
   endtask

   task automatic test_stall;
      logic [31:0] held;
      do_reset();
      repeat (3) step();
      id_ready = 1'b0;
      #1;
      held = mem[2];
      for (int i = 0; i < 3; i++) begin
         n_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || mem_addr !== AW'(2) || if_instr !== held)
            begin n_fail++; $display("FAIL stall_hold i=%0d got v=%0b pc=%h addr=%h instr=%h want pc=8 addr=2 instr=%h", i, if_valid, if_pc, mem_addr, if_instr, held); end
         step();
      end
      id_ready = 1'b1;
      #1;
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin n_fail++; $display("FAIL stall_release got pc=%h want 8", if_pc); end
      step();
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem[3])
         begin n_fail++; $display("FAIL stall_next got v=%0b pc=%h want pc=c", if_valid, if_pc); end
   endtask

   task automatic test_redirect;
      do_reset();
      repeat (5) step();
      n_run++; if (if_pc !== 32'h10) begin n_fail++; $display("FAIL redir_setup got pc=%h want 10", if_pc); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      #1;
      n_run++; if (if_valid !== 1'b0 || mem_addr !== AW'(16))
         begin n_fail++; $display("FAIL redir_kill got v=%0b addr=%h want v=0 addr=10", if_valid, mem_addr); end
      step();
      redirect_valid = 1'b0;
      #1;
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem[16])
         begin n_fail++; $display("FAIL redir_target got v=%0b pc=%h instr=%h want pc=40 instr=%h", if_valid, if_pc, if_instr, mem[16]); end
      step();
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'h44)
         begin n_fail++; $display("FAIL redir_seq got pc=%h want 44", if_pc); end
   endtask

   task automatic test_halt;
      do_reset();
      repeat (3) step();
      halt = 1'b1;
      #1;
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'h8)
         begin n_fail++; $display("FAIL halt_deliver got v=%0b pc=%h want v=1 pc=8", if_valid, if_pc); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_run++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_idle i=%0d got v=%0b want 0", i, if_valid); end
      end
      halt = 1'b0;
      step();
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem[3])
         begin n_fail++; $display("FAIL halt_resume got v=%0b pc=%h want pc=c", if_valid, if_pc); end
   endtask

   task automatic test_async_reset;
      do_reset();
      repeat (4) step();
      #1;
      rst_n = 1'b0;
      #1;
      n_run++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || fault !== 1'b0 || mem_addr !== '0)
         begin n_fail++; $display("FAIL async_rst got v=%0b pc=%h f=%0b addr=%h want all 0", if_valid, if_pc, fault, mem_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

`ifdef IF_BOUNDS_CHECK_EN
   task automatic test_fault;
      do_reset();
      repeat (2) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h1002;
      step();
      redirect_valid = 1'b0;
      #1;
      n_run++; if (fault !== 1'b1 || if_valid !== 1'b0)
         begin n_fail++; $display("FAIL fault_set got f=%0b v=%0b want f=1 v=0", fault, if_valid); end
      step();
      n_run++; if (fault !== 1'b1 || if_valid !== 1'b0)
         begin n_fail++; $display("FAIL fault_sticky got f=%0b v=%0b want f=1 v=0", fault, if_valid); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      #1;
      n_run++; if (fault !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0)
         begin n_fail++; $display("FAIL fault_clear got f=%0b v=%0b pc=%h want f=0 v=1 pc=0", fault, if_valid, if_pc); end
   endtask
`else
   task automatic test_wrap;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'h1000;
      #1;
      n_run++; if (mem_addr !== '0 || fault !== 1'b0)
         begin n_fail++; $display("FAIL wrap_1000 got addr=%h f=%0b want 0 0", mem_addr, fault); end
      redirect_pc = 32'hFF8;
      #1;
      n_run++; if (mem_addr !== AW'(10'h3FE)) begin n_fail++; $display("FAIL wrap_start got addr=%h want 3fe", mem_addr); end
      step();
      redirect_valid = 1'b0;
      #1;
      step();
      step();
      n_run++; if (if_valid !== 1'b1 || if_pc !== 32'h1000 || if_instr !== mem[0] || mem_addr !== AW'(1))
         begin n_fail++; $display("FAIL wrap_end got pc=%h instr=%h addr=%h want pc=1000 instr=%h addr=1", if_pc, if_instr, mem_addr, mem[0]); end
   endtask
`endif

   // Randomized run. The model tracks the fetch stream as "which PC decode is
   // offered next" rather than mirroring the RTL's registers.
   task automatic test_random;
      logic        m_valid;
      logic [31:0] m_pc;
      logic [31:0] m_seq;
      logic [31:0] exp_fetch;
      logic        took;
      do_reset();
      m_valid = 1'b0;
      m_pc = 32'h0;
      m_seq = 32'h0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         id_ready       = ($urandom_range(0, 3) != 0);
         halt           = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = {21'h0, 9'($urandom_range(0, 511)), 2'b00};
         #1;
         took = !m_valid || id_ready;
         exp_fetch = redirect_valid ? redirect_pc : (took ? m_seq : m_pc);
         n_run++; if (if_valid !== (m_valid & !redirect_valid))
            begin n_fail++; $display("FAIL rand_valid cyc=%0d got %0b want %0b", cyc, if_valid, m_valid & !redirect_valid); end
         n_run++; if (mem_addr !== exp_fetch[AW+1:2])
            begin n_fail++; $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, mem_addr, exp_fetch[AW+1:2]); end
         if (m_valid && !redirect_valid) begin
            n_run++; if (if_pc !== m_pc || if_pc_plus4 !== m_pc + 32'd4 || if_instr !== word_at(m_pc))
               begin n_fail++; $display("FAIL rand_word cyc=%0d got pc=%h instr=%h want pc=%h instr=%h", cyc, if_pc, if_instr, m_pc, word_at(m_pc)); end
         end
         n_run++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rand_fault cyc=%0d got %0b want 0", cyc, fault); end
         if (redirect_valid || took) begin
            m_valid = !halt;
            m_pc    = exp_fetch;
            m_seq   = halt ? exp_fetch : exp_fetch + 32'd4;
         end
         step();
      end
      halt = 1'b0;
      redirect_valid = 1'b0;
      id_ready = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      rst_n = 1'b0;
      id_ready = 1'b1;
      halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_halt();
      test_async_reset();
`ifdef IF_BOUNDS_CHECK_EN
      test_fault();
`else
      test_wrap();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
